// File: rtl/syscall_io_unit.sv
// Executes decoder-flagged print-int / read-int syscalls, stalling the core until the board I/O handshake finishes.
// Latency: print done 1 cycle after accept with out_ready high; read done 2 cycles after in_valid.
// Backpressure: out_valid/out_data held until out_ready, in_ready held until in_valid. SYSCALL_EXIT_EN adds absorbing HALT.
module syscall_io_unit #(
   parameter int DATA_W   = 32,
   parameter int V0_PRINT = 1,
   parameter int V0_READ  = 5,
   parameter int V0_EXIT  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sys_req,
   input  logic              sys_dir,
   input  logic [DATA_W-1:0] v0,
   input  logic [DATA_W-1:0] a0,
   output logic              stall,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wb_en,
   output logic [DATA_W-1:0] wb_data,
   output logic [15:0]       sys_cnt,
   output logic              halted
);

   localparam logic [DATA_W-1:0] CODE_PRINT = DATA_W'(V0_PRINT);
   localparam logic [DATA_W-1:0] CODE_READ  = DATA_W'(V0_READ);
   localparam logic [DATA_W-1:0] CODE_EXIT  = DATA_W'(V0_EXIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OUT,
      S_IN,
      S_WB,
      S_DONE
`ifdef SYSCALL_EXIT_EN
      , S_HALT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [15:0]       sys_cnt_q, sys_cnt_d;

   logic acc_print, acc_read, acc_exit;

   assign acc_print = sys_req & ~sys_dir & (v0 == CODE_PRINT);
   assign acc_read  = sys_req &  sys_dir & (v0 == CODE_READ);
   assign acc_exit  = sys_req & (v0 == CODE_EXIT);

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      wb_data_d  = wb_data_q;
      sys_cnt_d  = sys_cnt_q;
      stall      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Stall is combinational so the syscall never leaves decode.
            if (acc_print) begin
               stall      = 1'b1;
               out_data_d = a0;
               state_d    = S_OUT;
            end else if (acc_read) begin
               stall   = 1'b1;
               state_d = S_IN;
`ifdef SYSCALL_EXIT_EN
            end else if (acc_exit) begin
               stall     = 1'b1;
               sys_cnt_d = sys_cnt_q + 16'd1;
               state_d   = S_HALT;
`endif
            end
         end
         S_OUT: begin
            stall = 1'b1;
            if (out_ready) state_d = S_DONE;
         end
         S_IN: begin
            stall = 1'b1;
            if (in_valid) begin
               wb_data_d = in_data;
               state_d   = S_WB;
            end
         end
         S_WB: begin
            stall   = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            // Syscall still sits in decode here; its sys_req must not re-trigger.
            sys_cnt_d = sys_cnt_q + 16'd1;
            state_d   = S_IDLE;
         end
`ifdef SYSCALL_EXIT_EN
         S_HALT: begin
            stall = 1'b1;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         out_data_q <= '0;
         wb_data_q  <= '0;
         sys_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         wb_data_q  <= wb_data_d;
         sys_cnt_q  <= sys_cnt_d;
      end
   end

   assign out_valid = (state_q == S_OUT);
   assign in_ready  = (state_q == S_IN);
   assign wb_en     = (state_q == S_WB);
   assign out_data  = out_data_q;
   assign wb_data   = wb_data_q;
   assign sys_cnt   = sys_cnt_q;

`ifdef SYSCALL_EXIT_EN
   assign halted = (state_q == S_HALT);
`else
   // Exit code still decodes but is treated like any unknown code.
   logic unused_exit;
   assign unused_exit = acc_exit;
   assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_syscall_io_unit.sv
// Randomized scoreboard bench for syscall_io_unit: drivers push expected results, a monitor pops on each output event.
module tb_syscall_io_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sys_req, sys_dir;
   logic [W-1:0]  v0, a0;
   logic          stall;
   logic [W-1:0]  out_data;
   logic          out_valid, out_ready;
   logic [W-1:0]  in_data;
   logic          in_valid, in_ready;
   logic          wb_en;
   logic [W-1:0]  wb_data;
   logic [15:0]   sys_cnt;
   logic          halted;

   syscall_io_unit #(.DATA_W(W)) dut (
      .clk(clk), .rst(rst), .sys_req(sys_req), .sys_dir(sys_dir), .v0(v0), .a0(a0),
      .stall(stall), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .wb_en(wb_en), .wb_data(wb_data), .sys_cnt(sys_cnt), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_read;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          model_cnt = 0;     // completed syscalls since reset
   logic [31:0] last_rd = '0;      // value $v0 should hold from the last read

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] cnt_exp();
      return 32'(model_cnt & 32'hFFFF);
   endfunction

   // Monitor: compares every display handshake and every $v0 write against the scoreboard.
   initial begin : monitor
      logic        prev_wb;
      logic        held_vld;
      logic [31:0] held;
      exp_t        e;
      prev_wb  = 1'b0;
      held_vld = 1'b0;
      held     = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_wb  = 1'b0;
            held_vld = 1'b0;
            continue;
         end
         if (out_valid) begin
            if (held_vld) chk("out_data_stable", out_data, held);
            held     = out_data;
            held_vld = 1'b1;
            if (out_ready) begin
               held_vld = 1'b0;
               if (exp_q.size() == 0) chk("print_unexpected", 32'(out_valid), 32'd0);
               else begin
                  e = exp_q.pop_front();
                  chk("print_kind", 32'(e.is_read), 32'd0);
                  chk("print_data", out_data, e.val);
               end
            end
         end else held_vld = 1'b0;
         if (wb_en) begin
            chk("wb_single_cycle", 32'(prev_wb), 32'd0);
            if (exp_q.size() == 0) chk("wb_unexpected", 32'(wb_en), 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("wb_kind", 32'(e.is_read), 32'd1);
               chk("wb_data", wb_data, e.val);
            end
         end
         prev_wb = wb_en;
      end
   end

   task automatic idle_inputs();
      sys_req   = 1'b0;
      sys_dir   = 1'($urandom_range(0, 1));
      v0        = 32'($urandom_range(0, 15));
      a0        = $urandom;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         chk("idle_stall", 32'(stall), 32'd0);
         chk("idle_in_ready", 32'(in_ready), 32'd0);
         chk("idle_sys_cnt", 32'(sys_cnt), cnt_exp());
      end
   endtask

   // Print: out_ready held low for k OUT cycles, so stall lasts k+2 cycles.
   task automatic do_print(input logic [31:0] val, input int k);
      @(negedge clk);
      sys_req = 1'b1; sys_dir = 1'b0; v0 = 32'd1; a0 = val;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      exp_q.push_back('{is_read: 1'b0, val: val});
      #1;
      chk("print_stall_accept", 32'(stall), 32'd1);
      chk("print_valid_accept", 32'(out_valid), 32'd0);
      chk("print_sys_cnt", 32'(sys_cnt), cnt_exp());
      chk("wb_data_hold", wb_data, last_rd);
      for (int j = 1; j <= k + 1; j++) begin
         @(negedge clk);
         out_ready = (j > k);
         a0        = $urandom;
         in_valid  = 1'($urandom_range(0, 1));
         #1;
         chk("print_stall_out", 32'(stall), 32'd1);
         chk("print_out_valid", 32'(out_valid), 32'd1);
         chk("print_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("print_stall_done", 32'(stall), 32'd0);
      chk("print_valid_done", 32'(out_valid), 32'd0);
      model_cnt++;
   endtask

   // Read: k idle IN cycles then in_valid; stall lasts k+3 cycles, wb_en on the cycle after in_valid.
   task automatic do_read(input logic [31:0] val, input int k);
      @(negedge clk);
      sys_req = 1'b1; sys_dir = 1'b1; v0 = 32'd5;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      exp_q.push_back('{is_read: 1'b1, val: val});
      #1;
      chk("read_stall_accept", 32'(stall), 32'd1);
      chk("read_in_ready_accept", 32'(in_ready), 32'd0);
      chk("read_sys_cnt", 32'(sys_cnt), cnt_exp());
      for (int j = 1; j <= k + 1; j++) begin
         @(negedge clk);
         in_valid = (j > k);
         in_data  = (j > k) ? val : $urandom;
         #1;
         chk("read_stall_in", 32'(stall), 32'd1);
         chk("read_in_ready", 32'(in_ready), 32'd1);
         chk("read_wb_early", 32'(wb_en), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      #1;
      chk("read_stall_wb", 32'(stall), 32'd1);
      chk("read_wb_en", 32'(wb_en), 32'd1);
      chk("read_in_ready_wb", 32'(in_ready), 32'd0);
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      #1;
      chk("read_stall_done", 32'(stall), 32'd0);
      chk("read_wb_done", 32'(wb_en), 32'd0);
      chk("read_wb_data_hold", wb_data, val);
      model_cnt++;
      last_rd = val;
   endtask

   // Requests the unit must ignore: no stall, no handshakes, count unchanged.
   task automatic do_ignored(input logic [31:0] code, input logic dir, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sys_req = 1'b1; sys_dir = dir; v0 = code; a0 = $urandom;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         #1;
         chk("ign_stall", 32'(stall), 32'd0);
         chk("ign_out_valid", 32'(out_valid), 32'd0);
         chk("ign_in_ready", 32'(in_ready), 32'd0);
         chk("ign_halted", 32'(halted), 32'd0);
         chk("ign_sys_cnt", 32'(sys_cnt), cnt_exp());
      end
   endtask

   task automatic rand_ignored();
      logic [31:0] code;
      logic        dir;
      code = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) code = code | ($urandom & 32'hFFFF_FFE0);
      dir = 1'($urandom_range(0, 1));
      if ((code == 32'd1 && !dir) || (code == 32'd5 && dir)) code = code ^ 32'd8;
`ifdef SYSCALL_EXIT_EN
      if (code == 32'd10) code = 32'd11;
`endif
      do_ignored(code, dir, $urandom_range(1, 3));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_data"}, out_data, 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_wb_en"}, 32'(wb_en), 32'd0);
      chk({tag, "_wb_data"}, wb_data, 32'd0);
      chk({tag, "_sys_cnt"}, 32'(sys_cnt), 32'd0);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   task automatic do_reset_mid_in();
      @(negedge clk);
      sys_req = 1'b1; sys_dir = 1'b1; v0 = 32'd5; in_valid = 1'b0;
      exp_q.push_back('{is_read: 1'b1, val: 32'hDEAD_BEEF});
      @(negedge clk);
      #1;
      chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; sys_req = 1'b0;
      #1 rst = 1'b1;
      exp_q.delete();
      model_cnt = 0;
      last_rd   = '0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1;
      #1;
      check_reset_outputs("rst_release");
      do_idle(3);
   endtask

   initial begin : driver
      int r;
      idle_inputs();
      #1 rst = 1'b1;
      #3;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_idle(2);

      do_print(32'h0000_002A, 0);
      do_print($urandom, 5);
      do_read(32'h1234_5678, 0);
      do_read($urandom, 3);
      do_print($urandom, 1);
      do_ignored(32'd7, 1'b0, 2);
      do_ignored(32'd5, 1'b0, 2);
      do_ignored(32'd1, 1'b1, 2);
`ifndef SYSCALL_EXIT_EN
      do_ignored(32'd10, 1'b0, 2);
      do_ignored(32'd10, 1'b1, 2);
`endif
      do_idle(1);

      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      do_print($urandom, $urandom_range(0, 5));
         else if (r < 8) do_read($urandom, $urandom_range(0, 5));
         else if (r < 9) rand_ignored();
         else            do_idle($urandom_range(1, 3));
      end

      do_reset_mid_in();
      do_read($urandom, 2);
      do_print($urandom, 0);

`ifdef SYSCALL_EXIT_EN
      @(negedge clk);
      sys_req = 1'b1; sys_dir = 1'($urandom_range(0, 1)); v0 = 32'd10;
      #1;
      chk("exit_stall_accept", 32'(stall), 32'd1);
      chk("exit_halted_accept", 32'(halted), 32'd0);
      model_cnt++;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sys_req = 1'($urandom_range(0, 1));
         sys_dir = 1'($urandom_range(0, 1));
         v0      = 32'($urandom_range(0, 15));
         in_valid = 1'($urandom_range(0, 1));
         #1;
         chk("halt_halted", 32'(halted), 32'd1);
         chk("halt_stall", 32'(stall), 32'd1);
         chk("halt_sys_cnt", 32'(sys_cnt), cnt_exp());
         chk("halt_out_valid", 32'(out_valid), 32'd0);
         chk("halt_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      sys_req = 1'b0;
      #1 rst = 1'b1;
      model_cnt = 0;
      last_rd   = '0;
      #1;
      check_reset_outputs("halt_rst");
      @(negedge clk);
      rst = 1'b0;
      do_idle(2);
`endif

      do_idle(3);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
